// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - run controller for the counter/7-segment display path
//
// Loads a start value, steps the count up or down on each debounced clock
// edge, and either stops at or reloads from a programmed terminal value.
// Supports pause/resume and counts wrap events with saturation.
//
// Ports:
//   clk_o     in   1       debounced step clock, rising edge
//   reset     in   1       asynchronous, active-low reset
//   start     in   1       begin/restart a run (highest priority)
//   pause     in   1       freeze the run while high
//   dir       in   1       0 = count up, 1 = count down
//   wrap      in   1       1 = reload at terminal value, 0 = stop there
//   load_val  in   WIDTH   start value
//   limit     in   WIDTH   terminal value
//   count     out  WIDTH   current count (registered)
//   state     out  2       IDLE=00, RUN=01, PAUSE=10, DONE=11
//   done      out  1       high while in DONE
//   wraps     out  WRAP_W  wrap events in the current run, saturating

module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 4
) (
    input  logic              clk_o,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              dir,
    input  logic              wrap,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic [1:0]        state,
    output logic              done,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [WRAP_W-1:0] WRAPS_MAX = {WRAP_W{1'b1}};

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;

    always_ff @(posedge clk_o or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            wraps_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wraps_q <= wraps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wraps_d = wraps_q;

        // start overrides everything in every state: (re)load and run
        if (start) begin
            state_d = ST_RUN;
            count_d = load_val;
            wraps_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // pause has no meaning before a run exists
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (count_q == limit) begin
                        // terminal compare uses the pre-step count so the
                        // limit value is always visible for one edge
                        if (wrap) begin
                            count_d = load_val;
                            if (wraps_q != WRAPS_MAX) begin
                                wraps_d = wraps_q + WRAP_W'(1);
                            end
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (dir) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                ST_PAUSE: begin
                    // resume edge does not step
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign wraps = wraps_q;
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - self-checking bench for counter_sequencer

module tb_counter_sequencer;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic       clk_o;
    logic       reset;
    logic       start;
    logic       pause;
    logic       dir;
    logic       wrap;
    logic [3:0] load_val;
    logic [3:0] limit;
    logic [3:0] count;
    logic [1:0] state;
    logic       done;
    logic [3:0] wraps;

    typedef struct packed {
        logic [3:0] c;
        logic [1:0] s;
        logic       d;
        logic [3:0] w;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t obs;
    int   checks;
    int   failures;

    counter_sequencer #(.WIDTH(4), .WRAP_W(4)) dut (
        .clk_o    (clk_o),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .dir      (dir),
        .wrap     (wrap),
        .load_val (load_val),
        .limit    (limit),
        .count    (count),
        .state    (state),
        .done     (done),
        .wraps    (wraps)
    );

    initial clk_o = 1'b0;
    always #5 clk_o = ~clk_o;

    task automatic tick();
        @(posedge clk_o);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pause = 1'b0; dir = 1'b0; wrap = 1'b0;
        load_val = 4'd0; limit = 4'd0;
        #3;
        sb.push_back('{c: 4'd0, s: S_IDLE, d: 1'b0, w: 4'd0});
        e = sb.pop_front();
        obs = '{c: count, s: state, d: done, w: wraps};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_state: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                     obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
        end
        tick();
        reset = 1'b1;
        // pause in IDLE is ignored
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{c: 4'd0, s: S_IDLE, d: 1'b0, w: 4'd0});
            tick();
            e = sb.pop_front();
            obs = '{c: count, s: state, d: done, w: wraps};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL idle_pause edge %0d: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                         i, obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_up_stop();
        logic [3:0] cs [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5};
        logic [1:0] ss [6] = '{S_RUN, S_RUN, S_RUN, S_RUN, S_DONE, S_DONE};
        load_val = 4'd2; limit = 4'd5; dir = 1'b0; wrap = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            sb.push_back('{c: cs[i], s: ss[i], d: (ss[i] == S_DONE), w: 4'd0});
            tick();
            e = sb.pop_front();
            obs = '{c: count, s: state, d: done, w: wraps};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL up_stop edge %0d: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                         i, obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] cs [6] = '{4'd1, 4'd0, 4'd15, 4'd14, 4'd14, 4'd14};
        logic [1:0] ss [6] = '{S_RUN, S_RUN, S_RUN, S_RUN, S_DONE, S_DONE};
        load_val = 4'd1; limit = 4'd14; dir = 1'b1; wrap = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            sb.push_back('{c: cs[i], s: ss[i], d: (ss[i] == S_DONE), w: 4'd0});
            tick();
            e = sb.pop_front();
            obs = '{c: count, s: state, d: done, w: wraps};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL down_wrap edge %0d: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                         i, obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        int ec;
        int ew;
        load_val = 4'd3; limit = 4'd4; dir = 1'b0; wrap = 1'b1;
        ec = 3; ew = 0;
        for (int i = 0; i < 40; i++) begin
            start = (i == 0);
            if (i > 0) begin
                if (ec == 4) begin
                    ec = 3;
                    ew = (ew < 15) ? ew + 1 : 15;
                end else begin
                    ec = ec + 1;
                end
            end
            sb.push_back('{c: 4'(ec), s: S_RUN, d: 1'b0, w: 4'(ew)});
            tick();
            e = sb.pop_front();
            obs = '{c: count, s: state, d: done, w: wraps};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL wrap_sat edge %0d: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                         i, obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
            end
        end
        start = 1'b0;
        checks++;
        if (wraps !== 4'd15) begin
            failures++;
            $display("FAIL wrap_sat_final: got wraps=%0d, expected 15", wraps);
        end
    endtask

    task automatic test_pause();
        // start at 4, step to 6, pause 3 edges, resume without a step, then 7
        logic [3:0] cs [8] = '{4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7};
        logic [1:0] ss [8] = '{S_RUN, S_RUN, S_RUN, S_PAUSE, S_PAUSE, S_PAUSE, S_RUN, S_RUN};
        logic       ps [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        load_val = 4'd4; limit = 4'd12; dir = 1'b0; wrap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            pause = ps[i];
            sb.push_back('{c: cs[i], s: ss[i], d: 1'b0, w: 4'd0});
            tick();
            e = sb.pop_front();
            obs = '{c: count, s: state, d: done, w: wraps};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL pause edge %0d: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                         i, obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
            end
        end
        start = 1'b0; pause = 1'b0;
    endtask

    task automatic test_start_in_done();
        // load_val == limit: wrap=1 makes every edge a wrap, then wrap=0 stops,
        // then start+pause together in DONE restarts into RUN
        logic [3:0] cs [5] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd9};
        logic [1:0] ss [5] = '{S_RUN, S_RUN, S_RUN, S_DONE, S_RUN};
        logic [3:0] ws [5] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd0};
        load_val = 4'd7; limit = 4'd7; dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 0) || (i == 4);
            pause = (i == 4);
            wrap  = (i < 3);
            if (i == 4) load_val = 4'd9;
            sb.push_back('{c: cs[i], s: ss[i], d: (ss[i] == S_DONE), w: ws[i]});
            tick();
            e = sb.pop_front();
            obs = '{c: count, s: state, d: done, w: wraps};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL start_in_done edge %0d: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                         i, obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
            end
        end
        start = 1'b0; pause = 1'b0; wrap = 1'b0;
    endtask

    task automatic test_reset_midrun();
        load_val = 4'd9; limit = 4'd15; dir = 1'b0; wrap = 1'b0;
        start = 1'b1;
        sb.push_back('{c: 4'd9, s: S_RUN, d: 1'b0, w: 4'd0});
        tick();
        start = 1'b0;
        e = sb.pop_front();
        obs = '{c: count, s: state, d: done, w: wraps};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL midrun_load: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                     obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
        end
        // assert reset between edges, check before the next edge arrives
        #2;
        reset = 1'b0;
        sb.push_back('{c: 4'd0, s: S_IDLE, d: 1'b0, w: 4'd0});
        #1;
        e = sb.pop_front();
        obs = '{c: count, s: state, d: done, w: wraps};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL async_reset: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                     obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) reset = 1'b1;
            sb.push_back('{c: 4'd0, s: S_IDLE, d: 1'b0, w: 4'd0});
            tick();
            e = sb.pop_front();
            obs = '{c: count, s: state, d: done, w: wraps};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL after_reset edge %0d: got c=%0d s=%0d d=%0d w=%0d, expected c=%0d s=%0d d=%0d w=%0d",
                         i, obs.c, obs.s, obs.d, obs.w, e.c, e.s, e.d, e.w);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_up_stop();
        test_down_wrap();
        test_wrap_saturate();
        test_pause();
        test_start_in_done();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run controller for the 4-bit counter/7-segment display path. Loads a start value, steps the count up or down on each debounced clock edge, and stops or wraps at a programmed terminal value. Supports pause/resume. Its `count` output drives the BCD-to-7-segment decoder in place of a free-running ripple counter.

## Interface
Parameters:
- `WIDTH`, 4: count, `load_val` and `limit` width; arithmetic is modulo 2^WIDTH.
- `WRAP_W`, 4: width of the wrap-event counter.

Ports:
- `clk_o`  in  1: debounced step clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin or restart a run; level sampled at each `clk_o` rising edge.
- `pause`  in  1: freeze the run while high; level sampled.
- `dir`  in  1: 0 = count up, 1 = count down; sampled every RUN edge.
- `wrap`  in  1: 1 = reload at the terminal value and continue, 0 = stop at the terminal value.
- `load_val`  in  WIDTH: start value.
- `limit`  in  WIDTH: terminal value.
- `count`  out  WIDTH: current count, registered.
- `state`  out  2: FSM state, with IDLE=00, RUN=01, PAUSE=10, DONE=11.
- `done`  out  1: high while in DONE (level, not a pulse).
- `wraps`  out  WRAP_W: number of wrap events in the current run; saturates at 2^WRAP_W-1.

## Operation
- Reset (async, `reset`=0):
  - `count`=0, `state`=IDLE, `done`=0, `wraps`=0.
  - Holds while `reset`=0.
- Priority at each edge: `start` > `pause` > normal step.
- IDLE:
  - `start`=1: `count`<=`load_val`, `wraps`<=0, go to RUN.
  - Otherwise hold all outputs. `pause` is ignored.
- RUN:
  - `start`=1: restart, i.e. `count`<=`load_val`, `wraps`<=0, stay in RUN.
  - Else if `pause`=1: go to PAUSE; `count` is unchanged this edge.
  - Else if `count`==`limit` and `wrap`=1: `count`<=`load_val`; `wraps`<=`wraps`+1, saturating.
  - Else if `count`==`limit` and `wrap`=0: go to DONE; `count` holds at `limit`.
  - Otherwise: `count`<=`count`+1 when `dir`=0, `count`-1 when `dir`=1, modulo 2^WIDTH (15+1 -> 0, 0-1 -> 15).
- The terminal compare uses `count` before the step. The run therefore always shows `limit` for one edge before the wrap or stop.
- If `limit` is not reachable soon in the chosen direction, the count passes through 15/0 until it reaches `limit`. There is no error; every value is eventually reached.
- `load_val`==`limit`:
  - With `wrap`=0: the first RUN edge after start goes to DONE.
  - With `wrap`=1: every RUN edge is a wrap event.
- PAUSE:
  - `start`=1: restart into RUN.
  - Else if `pause`=0: go to RUN without stepping that edge.
  - Else hold.
- DONE:
  - `start`=1: restart into RUN.
  - Else hold, with `done`=1.
- `dir`, `wrap` and `limit` may change mid-run. They take effect on the next RUN edge.

## Timing
- Single clock domain `clk_o`. All outputs are registered and change only after a `clk_o` rising edge, or immediately on assertion of `reset`.
- `done` is decoded from the state register (`state`==DONE), so it is glitch-free and aligned with `state`.
- Latency:
  - `start` edge -> `count`=`load_val` after that same edge.
  - First step on the next edge.
- Run length: from start to DONE with `wrap`=0 takes N+2 edges, where N is the modulo distance from `load_val` to `limit` in the chosen direction. That is 1 load edge, N step edges and 1 terminate edge.
- Reset mid-run aborts immediately. The next edge after release is handled as IDLE.
- Inputs must be stable around `clk_o` edges. The debouncer upstream guarantees this.

## Test plan
- Reset, then `start`=1 for one edge with `load_val`=2, `limit`=5, `dir`=0, `wrap`=0 -> `count` 2,3,4,5,5 on successive edges. `state` reads DONE on the edge after `count` first shows 5, with `done`=1 and `wraps`=0.
- `load_val`=1, `limit`=14, `dir`=1, `wrap`=0 -> `count` 1,0,15,14 (wrap-around through 0), then DONE holding 14.
- `load_val`=3, `limit`=4, `dir`=0, `wrap`=1, run 40 edges -> `count` alternates 3,4. `wraps` increments on every edge where `count`=4 and saturates at 15.
- During RUN at `count`=6, assert `pause` for 3 edges -> `state`=PAUSE and `count` stays 6. Release `pause` -> one edge back to RUN with 6, then 7.
- `start` and `pause` both high in DONE -> `count`=`load_val`, `wraps`=0, `state`=RUN (start wins).
- Assert `reset` between edges mid-run at `count`=9 -> `count`=0, `state`=IDLE, `done`=0 immediately, without waiting for a `clk_o` edge.
